muon_frame_collector: RTL and testbench

MUON_FRAME_COLLECTOR -- requirements
Module: muon_frame_collector

---
 rtl/muon_frame_collector.sv | 124 ++++++++++++
 tb/tb_muon_frame_collector.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/muon_frame_collector.sv
// Collects a variable-length stream of muon candidates into a fixed WIDTH-slot frame for the bitonic sorter.
// Optional feature: define MUON_FRAME_COLLECTOR_FRAME_ID_EN to add an 8-bit m_frame_id output.

package bitonic_sorter_pkg;
  typedef struct packed {
    logic [7:0] pt;
    logic [3:0] eta;
    logic [3:0] phi;
  } muon_t;
endpackage

module muon_frame_collector
  import bitonic_sorter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  muon_t                      s_muon,
  input  logic                       s_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output muon_t                      m_frame [0:WIDTH-1],
  output logic [$clog2(WIDTH+1)-1:0] m_count,
`ifdef MUON_FRAME_COLLECTOR_FRAME_ID_EN
  output logic [7:0]                 m_frame_id,
`endif
  output logic                       m_overflow
);

  localparam int PW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {FILL, DRAIN, HOLD} state_t;

  state_t        state;
  logic [PW-1:0] wr_ptr;
  logic          s_fire;
  logic          m_fire;
  logic          frame_clear;

  // Ready depends only on state (and reset), never on m_ready.
  assign s_ready     = !rst && (state != HOLD);
  assign s_fire      = s_valid && s_ready;
  assign m_fire      = m_valid && m_ready;
  assign frame_clear = rst || m_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      wr_ptr     <= '0;
      m_count    <= '0;
      m_overflow <= 1'b0;
      m_valid    <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (s_fire) begin
            m_count <= CW'(wr_ptr) + CW'(1);
            if (s_last) begin
              state   <= HOLD;
              m_valid <= 1'b1;
            end else if (wr_ptr == PW'(WIDTH-1)) begin
              state <= DRAIN;
            end else begin
              wr_ptr <= wr_ptr + PW'(1);
            end
          end
        end
        DRAIN: begin
          // Excess candidates are dropped; only the overflow flag records them.
          if (s_fire) begin
            m_overflow <= 1'b1;
            if (s_last) begin
              state   <= HOLD;
              m_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (m_fire) begin
            state      <= FILL;
            m_valid    <= 1'b0;
            wr_ptr     <= '0;
            m_count    <= '0;
            m_overflow <= 1'b0;
          end
        end
        default: begin
          state   <= FILL;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

  // One register per slot; unwritten slots stay at the all-zero null muon.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slot
      muon_t slot_reg;
      always_ff @(posedge clk) begin
        if (frame_clear) begin
          slot_reg <= '0;
        end else if (state == FILL && s_fire && wr_ptr == PW'(gi)) begin
          slot_reg <= s_muon;
        end
      end
      assign m_frame[gi] = slot_reg;
    end
  endgenerate

`ifdef MUON_FRAME_COLLECTOR_FRAME_ID_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      m_frame_id <= 8'd0;
    end else if (m_fire) begin
      m_frame_id <= m_frame_id + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_muon_frame_collector.sv
// Self-checking bench for muon_frame_collector (WIDTH=4): vector table, corner sequences, randomized events.
// Frame-id checks are active when MUON_FRAME_COLLECTOR_FRAME_ID_EN is defined.
module tb_muon_frame_collector;
  import bitonic_sorter_pkg::*;

  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  muon_t       s_muon;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  muon_t       m_frame [0:W-1];
  logic [2:0]  m_count;
  logic        m_overflow;
`ifdef MUON_FRAME_COLLECTOR_FRAME_ID_EN
  logic [7:0]  m_frame_id;
`endif

  always #5 clk = ~clk;

  muon_frame_collector #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_muon     (s_muon),
    .s_last     (s_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_frame    (m_frame),
    .m_count    (m_count),
`ifdef MUON_FRAME_COLLECTOR_FRAME_ID_EN
    .m_frame_id (m_frame_id),
`endif
    .m_overflow (m_overflow)
  );

  typedef struct {
    int              n;
    int              bp;
    logic [0:7][7:0] in_pt;
    int              exp_count;
    bit              exp_ovf;
    logic [0:3][7:0] exp_pt;
  } vec_t;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] cur_pt [0:15];
  muon_t      exp_frame [0:W-1];
  int         exp_count;
  bit         exp_ovf;
  int         exp_id = 0;
  vec_t       vecs [0:6];

  function automatic muon_t mk(input logic [7:0] pt, input int idx);
    muon_t m;
    m.pt  = pt;
    m.eta = idx[3:0];
    m.phi = 4'(15 - idx);
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_hold(input string tag);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd1);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_m_count"}, 32'(m_count), 32'(exp_count));
    chk({tag, "_m_overflow"}, 32'(m_overflow), 32'(exp_ovf));
    for (int s = 0; s < W; s++)
      chk($sformatf("%s_slot%0d", tag, s), 32'(m_frame[s]), 32'(exp_frame[s]));
`ifdef MUON_FRAME_COLLECTOR_FRAME_ID_EN
    chk({tag, "_m_frame_id"}, 32'(m_frame_id), 32'(exp_id));
`endif
  endtask

  task automatic chk_empty(input string tag, input bit ready_exp);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'(ready_exp));
    chk({tag, "_m_count"}, 32'(m_count), 32'd0);
    chk({tag, "_m_overflow"}, 32'(m_overflow), 32'd0);
    for (int s = 0; s < W; s++)
      chk($sformatf("%s_null%0d", tag, s), 32'(m_frame[s]), 32'd0);
  endtask

  // Reference: the frame keeps the first W candidates, pads with nulls, flags anything beyond W.
  task automatic model(input int n);
    for (int s = 0; s < W; s++)
      exp_frame[s] = (s < n) ? mk(cur_pt[s], s) : muon_t'(0);
    exp_count = (n < W) ? n : W;
    exp_ovf   = (n > W);
  endtask

  task automatic send(input int n, input bit gaps, input bit close);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
        repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
      end
      s_valid = 1'b1;
      s_muon  = mk(cur_pt[i], i);
      s_last  = close && (i == n - 1);
      chk("s_ready_accept", 32'(s_ready), 32'd1);
      @(posedge clk); #1;
      if (!(close && i == n - 1)) chk("m_valid_mid", 32'(m_valid), 32'd0);
    end
  endtask

  task automatic run_event(input int n, input int bp, input bit gaps);
    send(n, gaps, 1'b1);
    // Junk offered while holding must be ignored.
    s_valid = 1'b1;
    s_muon  = mk(8'hEE, 9);
    s_last  = 1'b1;
    for (int c = 0; c < bp; c++) begin
      chk_hold("backpressure");
      @(posedge clk); #1;
    end
    chk_hold("hold");
    m_ready = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    @(posedge clk); #1;
    m_ready = 1'b0;
    exp_id  = (exp_id + 1) % 256;
    chk_empty("after_handshake", 1'b1);
    $display("event n=%0d bp=%0d count=%0d ovf=%0d", n, bp, exp_count, exp_ovf);
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    rst     = 1'b1;
    #1;
    chk("s_ready_in_reset", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    chk_empty("reset", 1'b0);
    rst    = 1'b0;
    exp_id = 0;
    #1;
    chk("s_ready_after_reset", 32'(s_ready), 32'd1);
  endtask

  initial begin
    vecs[0] = '{n:2, bp:0, in_pt:{8'd5, 8'd9, 48'd0}, exp_count:2, exp_ovf:1'b0,
                exp_pt:{8'd5, 8'd9, 8'd0, 8'd0}};
    vecs[1] = '{n:4, bp:0, in_pt:{8'd10, 8'd20, 8'd30, 8'd40, 32'd0}, exp_count:4, exp_ovf:1'b0,
                exp_pt:{8'd10, 8'd20, 8'd30, 8'd40}};
    vecs[2] = '{n:6, bp:0, in_pt:{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 16'd0}, exp_count:4, exp_ovf:1'b1,
                exp_pt:{8'd1, 8'd2, 8'd3, 8'd4}};
    vecs[3] = '{n:1, bp:5, in_pt:{8'd7, 56'd0}, exp_count:1, exp_ovf:1'b0,
                exp_pt:{8'd7, 8'd0, 8'd0, 8'd0}};
    vecs[4] = '{n:5, bp:2, in_pt:{8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 24'd0}, exp_count:4, exp_ovf:1'b1,
                exp_pt:{8'd11, 8'd12, 8'd13, 8'd14}};
    vecs[5] = '{n:3, bp:1, in_pt:{8'd3, 8'd4, 8'd5, 40'd0}, exp_count:3, exp_ovf:1'b0,
                exp_pt:{8'd3, 8'd4, 8'd5, 8'd0}};
    vecs[6] = '{n:8, bp:0, in_pt:{8'd21, 8'd22, 8'd23, 8'd24, 8'd25, 8'd26, 8'd27, 8'd28},
                exp_count:4, exp_ovf:1'b1, exp_pt:{8'd21, 8'd22, 8'd23, 8'd24}};

    rst     = 1'b1;
    s_valid = 1'b0;
    s_muon  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 8; i++) cur_pt[i] = vecs[v].in_pt[i];
      for (int s = 0; s < W; s++)
        exp_frame[s] = (vecs[v].exp_pt[s] == 8'd0) ? muon_t'(0) : mk(vecs[v].exp_pt[s], s);
      exp_count = vecs[v].exp_count;
      exp_ovf   = vecs[v].exp_ovf;
      run_event(vecs[v].n, vecs[v].bp, 1'b0);
    end

    // Reset in the middle of an event discards the partial frame.
    cur_pt[0] = 8'd31; cur_pt[1] = 8'd32; cur_pt[2] = 8'd33;
    send(3, 1'b0, 1'b0);
    do_reset();
    cur_pt[0] = 8'd42;
    for (int s = 0; s < W; s++) exp_frame[s] = muon_t'(0);
    exp_frame[0] = mk(8'd42, 0);
    exp_count = 1;
    exp_ovf   = 1'b0;
    run_event(1, 0, 1'b0);

    // Reset while a frame is held.
    cur_pt[0] = 8'd50; cur_pt[1] = 8'd51;
    send(2, 1'b0, 1'b1);
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("hold_before_reset", 32'(m_valid), 32'd1);
    do_reset();

    for (int r = 0; r < 40; r++) begin
      int n;
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) cur_pt[i] = 8'($urandom_range(1, 255));
      model(n);
      run_event(n, $urandom_range(0, 3), 1'b1);
    end

`ifdef MUON_FRAME_COLLECTOR_FRAME_ID_EN
    do_reset();
    for (int k = 0; k < 257; k++) begin
      cur_pt[0] = 8'((k % 255) + 1);
      model(1);
      run_event(1, 0, 1'b0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
